// File: rtl/matrix_mult_scheduler_if.sv
// Handshake bundle between the matrix scheduler, its matrix source/sink and the
// inner-product unit it feeds.
interface matrix_mult_scheduler_if #(
    parameter int N = 4,
    parameter int W = 32
);
    // Every stb is a request held until its ack; an ack counts on the rising edge
    // that samples it high while the matching stb is high, and is ignored otherwise.
    logic [W*N*N-1:0] in_a;
    logic [W*N*N-1:0] in_b;
    logic             in_stb;
    logic             in_ack;
    logic [W*N-1:0]   row;
    logic             row_stb;
    logic             row_ack;
    logic [W*N-1:0]   column;
    logic             column_stb;
    logic             column_ack;
    logic [W-1:0]     ip_out;
    logic             ip_stb;
    logic             ip_ack;
    logic [W*N*N-1:0] c_out;
    logic             c_stb;
    logic             c_ack;
    logic             busy;

    modport master (
        input  in_a, in_b, in_stb, row_ack, column_ack, ip_out, ip_stb, c_ack,
        output in_ack, row, row_stb, column, column_stb, ip_ack, c_out, c_stb, busy
    );

    modport slave (
        output in_a, in_b, in_stb, row_ack, column_ack, ip_out, ip_stb, c_ack,
        input  in_ack, row, row_stb, column, column_stb, ip_ack, c_out, c_stb, busy
    );
endinterface

// File: rtl/matrix_mult_scheduler.sv
// Walks every (i, j) of C = A x B in row-major order, handing row i of A and
// column j of B to an external inner-product unit and collecting each scalar.
module matrix_mult_scheduler #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_mult_scheduler_if.master bus,
    output logic [2:0]              state_dbg
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = W * N * N;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CW-1:0]   i_q, i_d, j_q, j_d;
    logic            row_seen_q, row_seen_d, col_seen_q, col_seen_d;
    logic            in_ack_q, in_ack_d;
    logic            stb_q, stb_d;
    logic            ip_ack_q, ip_ack_d;
    logic            c_stb_q, c_stb_d;
    logic [W*N-1:0]  row_sel, col_sel;
    int              elem;

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        elem    = int'(i_q) * N + int'(j_q);
        for (int k = 0; k < N; k++) begin
            row_sel[W*k +: W] = a_q[W*(int'(i_q)*N + k) +: W];
            col_sel[W*k +: W] = b_q[W*(k*N + int'(j_q)) +: W];
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        i_d        = i_q;
        j_d        = j_q;
        row_seen_d = row_seen_q;
        col_seen_d = col_seen_q;
        in_ack_d   = 1'b0;
        stb_d      = 1'b0;
        ip_ack_d   = 1'b0;
        c_stb_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_stb) begin
                    in_ack_d = 1'b1;
                    a_d      = bus.in_a;
                    b_d      = bus.in_b;
                    c_d      = '0;
                    i_d      = '0;
                    j_d      = '0;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                // Acks or a result still high from the previous element must
                // fall before a new request goes out.
                if (!bus.row_ack && !bus.column_ack && !bus.ip_stb) begin
                    stb_d      = 1'b1;
                    row_seen_d = 1'b0;
                    col_seen_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stb_d      = 1'b1;
                row_seen_d = row_seen_q | bus.row_ack;
                col_seen_d = col_seen_q | bus.column_ack;
                if (row_seen_d && col_seen_d) begin
                    stb_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ip_stb) begin
                    c_d[W*elem +: W] = bus.ip_out;
                    ip_ack_d         = 1'b1;
                    state_d          = S_NEXT;
                end
            end
            S_NEXT: begin
                if (i_q == LAST && j_q == LAST) begin
                    c_stb_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = S_PREP;
                end
            end
            S_DONE: begin
                c_stb_d = 1'b1;
                if (bus.c_ack) begin
                    c_stb_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            row_seen_q <= 1'b0;
            col_seen_q <= 1'b0;
            in_ack_q   <= 1'b0;
            stb_q      <= 1'b0;
            ip_ack_q   <= 1'b0;
            c_stb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            i_q        <= i_d;
            j_q        <= j_d;
            row_seen_q <= row_seen_d;
            col_seen_q <= col_seen_d;
            in_ack_q   <= in_ack_d;
            stb_q      <= stb_d;
            ip_ack_q   <= ip_ack_d;
            c_stb_q    <= c_stb_d;
        end
    end

    assign bus.in_ack     = in_ack_q;
    assign bus.row        = row_sel;
    assign bus.column     = col_sel;
    assign bus.row_stb    = stb_q;
    assign bus.column_stb = stb_q;
    assign bus.ip_ack     = ip_ack_q;
    assign bus.c_out      = c_q;
    assign bus.c_stb      = c_stb_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Bench for matrix_mult_scheduler: directed matrix jobs against a small
// integer-valued inner-product model, with queued expectations for operands and C.
module tb_matrix_mult_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MW = W * N * N;
    localparam int VW = W * N;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [W-1:0] INT_F [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state_dbg;

    matrix_mult_scheduler_if #(.N(N), .W(W)) bus ();
    matrix_mult_scheduler #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks;
    int            fails;
    int            c_rises;
    int            ip_mode;     // 0 immediate acks, 1 staggered acks, 2 never ack
    logic [MW-1:0] exp_q[$];
    logic [2*VW-1:0] pair_q[$];
    logic [MW-1:0] m_a1, m_b1, m_c1, m_ints, m_ident;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c,
                                          input logic [W-1:0] v);
        logic [MW-1:0] t;
        t = m;
        t[W*(r*N+c) +: W] = v;
        return t;
    endfunction

    // Exact for the small non-negative integers used here.
    function automatic int unsigned f2i(input logic [W-1:0] f);
        int e;
        e = int'(f[30:23]);
        if (e < 127 || e > 150) return 0;
        return {8'd0, 1'b1, f[22:0]} >> (150 - e);
    endfunction

    function automatic logic [W-1:0] i2f(input int unsigned v);
        int p;
        logic [31:0] m;
        if (v == 0) return '0;
        p = 0;
        for (int b = 0; b < 32; b++) if (v[b]) p = b;
        m = v << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [W-1:0] dot(input logic [VW-1:0] r, input logic [VW-1:0] c);
        int unsigned s;
        s = 0;
        for (int k = 0; k < N; k++) s += f2i(r[W*k +: W]) * f2i(c[W*k +: W]);
        return i2f(s);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c);
        logic [VW-1:0] rw, cl;
        exp_q.push_back(c);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < N; k++) begin
                    rw[W*k +: W] = a[W*(i*N+k) +: W];
                    cl[W*k +: W] = b[W*(k*N+j) +: W];
                end
                pair_q.push_back({rw, cl});
            end
        end
    endtask

    task automatic load_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c);
        int n;
        push_job(a, b, c);
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.in_ack && n < 50);
        check("in_ack_seen", MW'(bus.in_ack), MW'(1));
        check("c_cleared_on_accept", bus.c_out, '0);
        bus.in_stb = 1'b0;
    endtask

    task automatic wait_c_stb();
        int n;
        n = 0;
        while (!bus.c_stb && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("c_stb_seen", MW'(bus.c_stb), MW'(1));
    endtask

    task automatic finish_job(input int delay);
        wait_c_stb();
        repeat (delay) begin @(posedge clk); #1; end
        bus.c_ack = 1'b1;
        @(posedge clk); #1;
        bus.c_ack = 1'b0;
        check("c_stb_drop", MW'(bus.c_stb), '0);
        check("idle_after_ack", MW'(state_dbg), MW'(ST_IDLE));
    endtask

    // ---------------- inner-product model + operand monitor ----------------
    initial begin
        int ph, cnt;
        logic [W-1:0] res;
        ph = 0; cnt = 0; res = '0;
        bus.row_ack = 1'b0; bus.column_ack = 1'b0; bus.ip_stb = 1'b0; bus.ip_out = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                ph = 0;
                bus.row_ack = 1'b0; bus.column_ack = 1'b0; bus.ip_stb = 1'b0;
            end else begin
                case (ph)
                    0: if (bus.row_stb && bus.column_stb) begin
                        if (pair_q.size() == 0) check("operands_unexpected", MW'({bus.row, bus.column}), '0);
                        else check("operands", MW'({bus.row, bus.column}), MW'(pair_q.pop_front()));
                        res = dot(bus.row, bus.column);
                        cnt = 0;
                        if (ip_mode == 2) ph = 5;
                        else begin
                            bus.row_ack    = 1'b1;
                            bus.column_ack = (ip_mode == 0);
                            ph = 1;
                        end
                    end
                    1: begin
                        cnt++;
                        if (ip_mode == 0) begin
                            check("stb_drop_after_acks", MW'({bus.row_stb, bus.column_stb}), '0);
                            bus.row_ack = 1'b0; bus.column_ack = 1'b0;
                            ph = 2; cnt = 0;
                        end else if (cnt < 3) begin
                            check("stb_held_one_ack", MW'({bus.row_stb, bus.column_stb}), MW'(3));
                            if (cnt == 2) bus.column_ack = 1'b1;
                        end else begin
                            check("stb_drop_after_late_ack", MW'({bus.row_stb, bus.column_stb}), '0);
                            ph = 2; cnt = 0;
                        end
                    end
                    2: begin
                        cnt++;
                        if (cnt == 3) begin
                            bus.ip_out = res;
                            bus.ip_stb = 1'b1;
                            ph = 3;
                        end
                    end
                    3: if (bus.ip_ack) begin
                        bus.ip_stb = 1'b0;
                        cnt = 0;
                        ph = (ip_mode == 1) ? 4 : 0;
                    end
                    4: begin
                        cnt++;
                        check("prep_blocked_by_acks", MW'({bus.row_stb, bus.column_stb, bus.ip_ack}), '0);
                        if (cnt == 3) begin
                            bus.row_ack = 1'b0; bus.column_ack = 1'b0;
                            ph = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- C monitor ----------------
    initial begin
        logic          prev;
        logic [MW-1:0] held;
        int            ipc;
        prev = 1'b0; held = '0; ipc = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                prev = 1'b0; ipc = 0;
            end else begin
                if (bus.in_ack) ipc = 0;
                if (bus.ip_ack) ipc++;
                if (bus.c_stb && !prev) begin
                    c_rises++;
                    if (exp_q.size() == 0) begin
                        held = '0;
                        check("c_out_unexpected", bus.c_out, '0);
                    end else begin
                        held = exp_q.pop_front();
                        check("c_out", bus.c_out, held);
                    end
                    check("results_per_job", MW'(ipc), MW'(N*N));
                end else if (bus.c_stb) begin
                    check("c_out_stable", bus.c_out, held);
                    check("no_in_ack_in_done", MW'(bus.in_ack), '0);
                end
                prev = bus.c_stb;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        checks = 0; fails = 0; c_rises = 0; ip_mode = 0;
        bus.in_a = '0; bus.in_b = '0; bus.in_stb = 1'b0; bus.c_ack = 1'b0;

        m_a1 = '0; m_b1 = '0; m_c1 = '0; m_ints = '0; m_ident = '0;
        m_a1 = put(m_a1, 0, 0, 32'h3F800000); m_a1 = put(m_a1, 0, 1, 32'h40000000);
        m_a1 = put(m_a1, 1, 0, 32'h40400000); m_a1 = put(m_a1, 1, 1, 32'h40800000);
        m_b1 = put(m_b1, 0, 0, 32'h40A00000); m_b1 = put(m_b1, 0, 1, 32'h40C00000);
        m_b1 = put(m_b1, 1, 0, 32'h40E00000); m_b1 = put(m_b1, 1, 1, 32'h41000000);
        m_c1 = put(m_c1, 0, 0, 32'h41980000); m_c1 = put(m_c1, 0, 1, 32'h41B00000);
        m_c1 = put(m_c1, 1, 0, 32'h422C0000); m_c1 = put(m_c1, 1, 1, 32'h42480000);
        for (int r = 0; r < N; r++) begin
            m_ident = put(m_ident, r, r, 32'h3F800000);
            for (int c = 0; c < N; c++) m_ints = put(m_ints, r, c, INT_F[r*N+c]);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", MW'(bus.busy), '0);
        check("rst_strobes", MW'({bus.in_ack, bus.row_stb, bus.column_stb, bus.ip_ack, bus.c_stb}), '0);
        check("rst_c_out", bus.c_out, '0);
        check("rst_state", MW'(state_dbg), MW'(ST_IDLE));
        @(negedge clk) rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("idle_no_in_ack", MW'({bus.in_ack, bus.busy}), '0); end

        // 2x2 product embedded in the top-left corner
        load_job(m_a1, m_b1, m_c1);
        check("busy_while_running", MW'(bus.busy), MW'(1));
        finish_job(0);

        // Identity x distinct words: C = B, operands checked element by element
        load_job(m_ident, m_ints, m_ints);
        finish_job(0);

        // Staggered acks held through WAIT
        ip_mode = 1;
        load_job(m_ints, m_ident, m_ints);
        finish_job(0);
        ip_mode = 0;

        // Output backpressure with the next job already requesting, then back-to-back
        load_job(m_a1, m_b1, m_c1);
        wait_c_stb();
        push_job(m_ident, m_ints, m_ints);
        bus.in_a = m_ident; bus.in_b = m_ints; bus.in_stb = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        bus.c_ack = 1'b1;
        @(posedge clk); #1;
        bus.c_ack = 1'b0;
        check("bp_c_stb_drop", MW'(bus.c_stb), '0);
        check("bp_no_in_ack_on_reentry", MW'(bus.in_ack), '0);
        @(posedge clk); #1;
        check("bp_in_ack_next_cycle", MW'(bus.in_ack), MW'(1));
        check("bp_c_cleared", bus.c_out, '0);
        bus.in_stb = 1'b0;
        finish_job(0);

        // Reset in the middle of ISSUE after two results have landed
        bus.in_a = m_ints; bus.in_b = m_ident; bus.in_stb = 1'b1;
        push_job(m_ints, m_ident, m_ints);
        n = 0;
        while (n < 2 && checks < 100000) begin
            @(posedge clk); #1;
            if (bus.in_ack) bus.in_stb = 1'b0;
            if (bus.ip_ack) n++;
            if (c_rises > 100000) n = 2;
        end
        ip_mode = 2;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (state_dbg != ST_ISSUE && n < 50);
        check("reached_issue", MW'(state_dbg), MW'(ST_ISSUE));
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        check("midrst_strobes", MW'({bus.row_stb, bus.column_stb, bus.ip_ack, bus.c_stb, bus.in_ack}), '0);
        check("midrst_busy", MW'(bus.busy), '0);
        check("midrst_c_out", bus.c_out, '0);
        exp_q.delete();
        pair_q.delete();
        ip_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (5) begin @(posedge clk); #1; check("post_rst_idle", MW'({bus.in_ack, bus.busy}), '0); end

        // Fresh job after reset
        load_job(m_a1, m_b1, m_c1);
        finish_job(0);

        repeat (3) @(posedge clk);
        #1;
        check("c_stb_assertions", MW'(c_rises), MW'(6));
        check("queues_drained", MW'(exp_q.size() + pair_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
